qspi_slave_engine: RTL and testbench

//  Parametrised SPI slave datapath: SPI mode 0, 1/2/4 lanes selected at run time, sclk/cs oversampled in the clk_i domain.

---
 rtl/qspi_slv_pkg.sv | 36 +++
 rtl/qspi_slv_sync.sv | 34 +++
 rtl/qspi_slave_engine.sv | 197 +++++++++++++++++++
 tb/tb_qspi_slave_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_slv_pkg.sv
// Shared types and helpers for the SPI slave engine: lane modes, FSM state,
// debug view of the controller, lane-count decode and a bitwise CRC-8 step.
package qspi_slv_pkg;

  typedef enum logic [1:0] {
    QSPI_SINGLE = 2'd0,
    QSPI_DUAL   = 2'd1,
    QSPI_QUAD   = 2'd2
  } qspi_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } qspi_state_e;

  typedef struct packed {
    qspi_state_e state;
    logic [1:0]  mode;
  } qspi_dbg_t;

  function automatic logic [2:0] lanes_of(input logic [1:0] mode);
    case (mode)
      QSPI_DUAL: return 3'd2;
      QSPI_QUAD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  // One MSB-first CRC-8 step, polynomial x^8 + x^2 + x + 1 (0x07).
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

endpackage

// File: rtl/qspi_slv_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs, with rise/fall pulses
// derived from the last two synchronised samples.
module qspi_slv_sync #(
  parameter int   WIDTH   = 1,
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= {WIDTH{RST_VAL}};
      prev <= {WIDTH{RST_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/qspi_slave_engine.sv
// SPI mode-0 slave datapath with run-time 1/2/4 lane selection, oversampled pads,
// valid/ready RX and TX word ports. Define QSPI_SLV_CRC8_EN to add crc_o.
//
// Handshakes: rx_data_o is transferred on any cycle where rx_valid_o && rx_ready_i;
// rx_valid_o then stays high only if a new word lands in that same cycle. On the TX
// side the engine pulls: tx_ready_o pulses for one cycle on the edge tx_data_i is taken.
module qspi_slave_engine
  import qspi_slv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MAX_LANES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_cs_i,
  input  logic                 spi_sclk_i,
  input  logic [MAX_LANES-1:0] spi_sdi_i,
  output logic [MAX_LANES-1:0] spi_sdo_o,
  output logic [MAX_LANES-1:0] spi_sdo_oe_o,
  input  logic [1:0]           mode_i,
  output logic [1:0]           spi_mode_o,
  output logic                 frame_active_o,
  output logic [DATA_W-1:0]    rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic [DATA_W-1:0]    tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 rx_overflow_o,
  output logic                 tx_underflow_o,
  input  logic                 err_clr_i
`ifdef QSPI_SLV_CRC8_EN
  ,
  output logic [7:0]           crc_o
`endif
);

  localparam int CW = $clog2(DATA_W + 1);

  logic                 cs_q, cs_rise_unused, cs_fall;
  logic                 sclk_q_unused, sclk_rise, sclk_fall;
  logic [MAX_LANES-1:0] sdi_q, sdi_rise_unused, sdi_fall_unused;

  qspi_slv_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk_i), .rst(rst_i), .d(spi_cs_i), .q(cs_q), .rise(cs_rise_unused), .fall(cs_fall)
  );
  qspi_slv_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk_i), .rst(rst_i), .d(spi_sclk_i), .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  qspi_slv_sync #(.WIDTH(MAX_LANES), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi_sync (
    .clk(clk_i), .rst(rst_i), .d(spi_sdi_i), .q(sdi_q), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  qspi_state_e       state;
  logic [CW-1:0]     bit_cnt, cnt_next;
  logic [DATA_W-1:0] rx_shift, rx_next, tx_shift, tx_next;
  logic              frame_start, word_done, tx_take;
  logic [3:0]        sdo4, oe4;
  qspi_dbg_t         dbg_unused;

  assign dbg_unused  = '{state: state, mode: spi_mode_o};
  assign cnt_next    = bit_cnt + CW'(lanes_of(spi_mode_o));
  assign frame_start = (state == ST_IDLE) && cs_fall;
  assign word_done   = sclk_rise && (cnt_next == CW'(DATA_W));
  // A falling edge seen with the counter at zero follows a word boundary.
  assign tx_take     = frame_start ||
                       ((state == ST_ACTIVE) && !cs_q && sclk_fall && (bit_cnt == '0));

  always_comb begin
    rx_next = {rx_shift[DATA_W-2:0], sdi_q[0]};
    tx_next = {tx_shift[DATA_W-2:0], 1'b0};
    case (spi_mode_o)
      QSPI_DUAL: begin
        rx_next = {rx_shift[DATA_W-3:0], sdi_q[1:0]};
        tx_next = {tx_shift[DATA_W-3:0], 2'b00};
      end
      QSPI_QUAD: begin
        rx_next = {rx_shift[DATA_W-5:0], sdi_q[3:0]};
        tx_next = {tx_shift[DATA_W-5:0], 4'b0000};
      end
      default: ;
    endcase
  end

  always_comb begin
    sdo4 = 4'b0000;
    oe4  = 4'b0000;
    if (state == ST_ACTIVE) begin
      case (spi_mode_o)
        QSPI_DUAL: begin
          sdo4 = {2'b00, tx_shift[DATA_W-1 -: 2]};
          oe4  = 4'b0011;
        end
        QSPI_QUAD: begin
          sdo4 = tx_shift[DATA_W-1 -: 4];
          oe4  = 4'b1111;
        end
        default: begin
          sdo4 = {2'b00, tx_shift[DATA_W-1], 1'b0};
          oe4  = 4'b0010;
        end
      endcase
    end
  end

  assign spi_sdo_o    = MAX_LANES'(sdo4);
  assign spi_sdo_oe_o = MAX_LANES'(oe4);

`ifdef QSPI_SLV_CRC8_EN
  logic [7:0] crc_r;

  function automatic logic [7:0] crc8_word(input logic [7:0] crc, input logic [DATA_W-1:0] w);
    logic [7:0] c;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) c = crc8_bit(c, w[i]);
    return c;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || frame_start) crc_r <= 8'h00;
    else if ((state == ST_ACTIVE) && !cs_q && word_done) crc_r <= crc8_word(crc_r, rx_next);
  end

  assign crc_o = crc_r;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      spi_mode_o     <= 2'd0;
      frame_active_o <= 1'b0;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      tx_ready_o     <= 1'b0;
      rx_overflow_o  <= 1'b0;
      tx_underflow_o <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      if (err_clr_i) begin
        rx_overflow_o  <= 1'b0;
        tx_underflow_o <= 1'b0;
      end
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state          <= ST_ACTIVE;
            frame_active_o <= 1'b1;
            spi_mode_o     <= (mode_i == 2'd3) ? 2'd0 : mode_i;
            bit_cnt        <= '0;
            rx_shift       <= '0;
          end
        end
        default: begin
          if (cs_q) begin
            state          <= ST_IDLE;
            frame_active_o <= 1'b0;
            bit_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= word_done ? '0 : cnt_next;
              if (word_done) begin
                if (!rx_valid_o || rx_ready_i) begin
                  rx_data_o  <= rx_next;
                  rx_valid_o <= 1'b1;
                end else begin
                  rx_overflow_o <= 1'b1;
                end
              end
            end
            if (sclk_fall && (bit_cnt != '0)) tx_shift <= tx_next;
          end
        end
      endcase

      // Pulled last so a fresh error overrides a same-cycle clear.
      if (tx_take) begin
        if (tx_valid_i) begin
          tx_shift   <= tx_data_i;
          tx_ready_o <= 1'b1;
        end else begin
          tx_shift       <= '0;
          tx_underflow_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_slave_engine.sv
// Bench for qspi_slave_engine: table of single-word frames per lane mode, then
// hand-written overflow, partial-frame, underflow and mid-frame reset sequences.
module tb_qspi_slave_engine;

  localparam int W = 32;
  localparam int H = 6;  // SPI half period in clk cycles

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         spi_cs_i = 1'b1;
  logic         spi_sclk_i = 1'b0;
  logic [3:0]   spi_sdi_i = 4'h0;
  logic [3:0]   spi_sdo_o, spi_sdo_oe_o;
  logic [1:0]   mode_i = 2'd0;
  logic [1:0]   spi_mode_o;
  logic         frame_active_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o;
  logic         rx_ready_i = 1'b1;
  logic [W-1:0] tx_data_i = '0;
  logic         tx_valid_i = 1'b0;
  logic         tx_ready_o;
  logic         rx_overflow_o, tx_underflow_o;
  logic         err_clr_i = 1'b0;
`ifdef QSPI_SLV_CRC8_EN
  logic [7:0]   crc_o;
`endif

  qspi_slave_engine #(.DATA_W(W), .MAX_LANES(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .spi_cs_i(spi_cs_i), .spi_sclk_i(spi_sclk_i),
    .spi_sdi_i(spi_sdi_i), .spi_sdo_o(spi_sdo_o), .spi_sdo_oe_o(spi_sdo_oe_o),
    .mode_i(mode_i), .spi_mode_o(spi_mode_o), .frame_active_o(frame_active_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_overflow_o(rx_overflow_o), .tx_underflow_o(tx_underflow_o), .err_clr_i(err_clr_i)
`ifdef QSPI_SLV_CRC8_EN
    , .crc_o(crc_o)
`endif
  );

  // Clock
  initial forever #5 clk = ~clk;

  int           chk_cnt = 0;
  int           pass_cnt = 0;
  int           rx_seen = 0;
  int           tx_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard consumer for RX words and the TX word source.
  initial forever begin
    @(negedge clk);
    if (rx_valid_o && rx_ready_i) begin
      rx_seen++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL rx_unexpected: got %h expected no word", rx_data_o);
      end else begin
        check("rx_word", rx_data_o, exp_q.pop_front());
      end
    end
    if (tx_ready_o) begin
      tx_pulses++;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    tx_valid_i = (tx_q.size() > 0);
    if (tx_q.size() > 0) tx_data_i = tx_q[0];
    else tx_data_i = '0;
  end

  // Driver tasks: all of them start and end just after a rising clk edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low(input logic [1:0] m);
    mode_i   = m;
    spi_cs_i = 1'b0;
    step(H);
  endtask

  task automatic cs_high();
    step(H);
    spi_cs_i = 1'b1;
    step(H);
  endtask

  task automatic beat(input logic [3:0] d, output logic [3:0] so);
    spi_sdi_i = d;
    step(H);
    so = spi_sdo_o;
    spi_sclk_i = 1'b1;
    step(H);
    spi_sclk_i = 1'b0;
  endtask

  function automatic int lanes(input logic [1:0] m);
    return (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
  endfunction

  // Sends the first nb beats of w MSB-first; unused lanes carry random junk.
  task automatic send(input logic [1:0] eff_mode, input logic [W-1:0] w, input int nb,
                      output logic [W-1:0] got);
    int         l;
    logic [3:0] d, so;
    l = lanes(eff_mode);
    got = '0;
    for (int b = 0; b < nb; b++) begin
      d = 4'($urandom_range(0, 15));
      for (int k = 0; k < l; k++) d[k] = w[W - l*(b+1) + k];
      beat(d, so);
      case (l)
        1:       got = {got[W-2:0], so[1]};
        2:       got = {got[W-3:0], so[1:0]};
        default: got = {got[W-5:0], so[3:0]};
      endcase
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] rx_w;
    logic [W-1:0] tx_w;
    logic [1:0]   exp_mode;
    logic [3:0]   exp_oe;
  } vec_t;

  vec_t         vecs[4];
  logic [W-1:0] got;
  int           s_rx, s_tx;

  initial begin
    vecs[0] = '{2'd0, 32'hA5A5_1234, 32'h1357_9BDF, 2'd0, 4'b0010};
    vecs[1] = '{2'd1, 32'h0F1E_2D3C, 32'hCAFE_F00D, 2'd1, 4'b0011};
    vecs[2] = '{2'd2, 32'h8765_4321, 32'hDEAD_BEEF, 2'd2, 4'b1111};
    vecs[3] = '{2'd3, 32'h5A5A_00FF, 32'h2468_1357, 2'd0, 4'b0010};

    // Reset state
    step(5);
    check("rst_sdo_oe", W'({spi_sdo_o, spi_sdo_oe_o}), '0);
    check("rst_ctrl", W'({spi_mode_o, frame_active_o, rx_valid_o, tx_ready_o,
                          rx_overflow_o, tx_underflow_o}), '0);
    check("rst_rx_data", rx_data_o, '0);
    rst_i = 1'b0;
    step(4);

    // Table: one word per frame in each lane mode
    foreach (vecs[i]) begin
      tx_q.push_back(vecs[i].tx_w);
      tx_q.push_back(32'h0);
      s_rx = rx_seen;
      s_tx = tx_pulses;
      step(2);
      cs_low(vecs[i].mode);
      check("frame_mode", W'(spi_mode_o), W'(vecs[i].exp_mode));
      check("frame_oe", W'({frame_active_o, spi_sdo_oe_o}), W'({1'b1, vecs[i].exp_oe}));
      exp_q.push_back(vecs[i].rx_w);
      send(vecs[i].exp_mode, vecs[i].rx_w, W / lanes(vecs[i].exp_mode), got);
      cs_high();
      check("tx_word", got, vecs[i].tx_w);
      check("rx_count", W'(rx_seen - s_rx), W'(1));
      check("tx_ready_count", W'(tx_pulses - s_tx), W'(2));
      check("no_errors", W'({rx_overflow_o, tx_underflow_o}), '0);
      check("idle_outputs", W'({frame_active_o, spi_sdo_o, spi_sdo_oe_o}), '0);
    end

    // Overflow: two quad words with consumer stalled
    rx_ready_i = 1'b0;
    repeat (3) tx_q.push_back(32'h0);
    s_rx = rx_seen;
    s_tx = tx_pulses;
    step(2);
    cs_low(2'd2);
    exp_q.push_back(32'h1234_5678);
    send(2'd2, 32'h1234_5678, 8, got);
    send(2'd2, 32'h9ABC_DEF0, 8, got);
    cs_high();
    check("ovf_held", rx_data_o, 32'h1234_5678);
    check("ovf_flags", W'({rx_valid_o, rx_overflow_o, tx_underflow_o}), W'(3'b110));
    check("ovf_tx_ready_count", W'(tx_pulses - s_tx), W'(3));
    rx_ready_i = 1'b1;
    step(3);
    check("ovf_drain", W'({rx_valid_o, 8'(rx_seen - s_rx)}), W'({1'b0, 8'd1}));
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check("ovf_cleared", W'(rx_overflow_o), '0);

    // Partial dual frame (12 bits) followed by a full word
    repeat (3) tx_q.push_back(32'h0);
    s_rx = rx_seen;
    step(2);
    cs_low(2'd1);
    send(2'd1, 32'hABCD_EF01, 6, got);
    cs_high();
    check("partial_no_word", W'({rx_valid_o, 8'(rx_seen - s_rx)}), '0);
    cs_low(2'd1);
    exp_q.push_back(32'h0000_00FF);
    send(2'd1, 32'h0000_00FF, 16, got);
    cs_high();
    check("partial_next_count", W'(rx_seen - s_rx), W'(1));

    // Underflow: no TX data offered
    cs_low(2'd0);
    exp_q.push_back(32'hC3C3_C3C3);
    send(2'd0, 32'hC3C3_C3C3, 32, got);
    cs_high();
    check("unf_sdo_zero", got, '0);
    check("unf_flag", W'({rx_overflow_o, tx_underflow_o}), W'(2'b01));
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check("unf_cleared", W'(tx_underflow_o), '0);

    // Reset in the middle of a quad frame
    tx_q.push_back(32'hFFFF_FFFF);
    step(2);
    cs_low(2'd2);
    send(2'd2, 32'h7777_7777, 3, got);
    check("mid_active", W'({frame_active_o, spi_sdo_oe_o}), W'(5'b11111));
    rst_i = 1'b1;
    step(1);
    check("midrst_sdo_oe", W'({spi_sdo_o, spi_sdo_oe_o}), '0);
    check("midrst_ctrl", W'({spi_mode_o, frame_active_o, rx_valid_o, tx_ready_o,
                             rx_overflow_o, tx_underflow_o}), '0);
    spi_cs_i = 1'b1;
    step(4);
    rst_i = 1'b0;
    tx_q.delete();
    step(H);
    check("post_rst_idle", W'({frame_active_o, rx_valid_o}), '0);

    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
